// File: rtl/fetch_queue.sv
// Instruction-fetch stage: holds the fetch PC, reads combinational imem and buffers {pc, word} pairs for decode.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect raises a sticky fault that stops fetching).
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  output logic        fetch_fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   load_pc;
  logic          push;
  logic          pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q;
  logic fault_d;

  assign load_pc = redirect_pc;

  // Fault survives later redirects; only reset clears it.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  logic fault_q;
  logic unused_redirect_lsbs;

  assign load_pc              = {redirect_pc[31:2], 2'b00};
  assign fault_q              = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // Push eligibility looks only at the registered count, so a pop never frees a slot in the same cycle.
  assign push = (count_q < CW'(DEPTH)) && !fault_q && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    fpc_d    = fpc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      fpc_d    = load_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        fpc_d    = fpc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fpc_q    <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fpc_q;
      word_mem[wr_ptr_q] <= imem_rd;
    end
  end

  assign imem_addr     = fpc_q;
  assign instr_valid   = (count_q != '0);
  assign instr         = instr_valid ? word_mem[rd_ptr_q] : 32'h0;
  assign instr_pc      = instr_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign instr_pcplus4 = instr_valid ? (pc_mem[rd_ptr_q] + 32'd4) : 32'h0;
  assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic, all checked against a queue-based model.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic        m_fault;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pcplus4  (instr_pcplus4),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0050_0113;
      32'd4:   return 32'h00C0_0193;
      32'd8:   return 32'hFF71_8393;
      32'd12:  return 32'h0023_E233;
      default: return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  assign imem_rd = imem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic v;
    v = (mq.size() != 0);
    chk("imem_addr", imem_addr, m_fpc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, v});
    chk("instr", instr, v ? mq[0].word : 32'h0);
    chk("instr_pc", instr_pc, v ? mq[0].pc : 32'h0);
    chk("instr_pcplus4", instr_pcplus4, v ? mq[0].pc + 32'd4 : 32'h0);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc   = RESET_PC;
    m_fault = 1'b0;
  endtask

  // Applies one clock of the architectural rules to the model using the current inputs.
  task automatic model_step();
    bit can_push;
    bit do_pop;
    ent_t e;
    if (!reset_n) begin
      model_reset();
    end else if (redirect_valid) begin
      mq.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      m_fpc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
`else
      m_fpc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      can_push = (mq.size() < DEPTH) && !m_fault;
      do_pop   = (mq.size() != 0) && instr_ready;
      if (do_pop) void'(mq.pop_front());
      if (can_push) begin
        e.pc   = m_fpc;
        e.word = imem_word(m_fpc);
        mq.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_target();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0:       return 32'd0;
      1:       return 32'd4;
      2:       return 32'd12;
      3:       return 32'hFFFF_FFFC;
      4:       return 32'hFFFF_FFF8;
      5:       return $urandom() | 32'd1;
      default: return $urandom() & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    reset_n        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();

    // Release reset with decode ready: back-to-back 0, 4, 8.
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    cycle();
    chk("rel_instr0", instr, 32'h0050_0113);
    chk("rel_pc0", instr_pc, 32'h0);
    chk("rel_pcp4_0", instr_pcplus4, 32'd4);
    cycle();
    chk("rel_instr1", instr, 32'h00C0_0193);
    cycle();
    chk("rel_instr2", instr, 32'hFF71_8393);

    // One-cycle reset pulse mid-stream.
    reset_n = 1'b0;
    cycle();
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // Stall decode until the queue saturates, then drain.
    reset_n     = 1'b1;
    instr_ready = 1'b0;
    repeat (5) cycle();
    chk("full_addr", imem_addr, 32'd8);
    chk("full_head", instr, 32'h0050_0113);
    instr_ready = 1'b1;
    cycle();
    chk("drain_pc4", instr_pc, 32'd4);
    cycle();
    chk("drain_pc8", instr_pc, 32'd8);

    // Redirect to 12 while full and ready.
    instr_ready = 1'b0;
    repeat (3) cycle();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd12;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_bubble", {31'b0, instr_valid}, 32'h0);
    cycle();
    chk("redir_instr", instr, 32'h0023_E233);
    chk("redir_pc", instr_pc, 32'd12);

    // Redirect to the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pcp4", instr_pcplus4, 32'h0);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    cycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
    cycle();
    chk("mis_valid", {31'b0, instr_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("mis_stuck", {31'b0, instr_valid}, 32'h0);
`else
    chk("mis_addr", imem_addr, 32'd4);
    cycle();
    chk("mis_pc", instr_pc, 32'd4);
`endif

    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n        = ($urandom_range(0, 99) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = pick_target();
      cycle();
    end
    redirect_valid = 1'b0;
    reset_n        = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
